// File: rtl/client_accum_ram.sv
// Per-client accumulator RAM: a one-deep read-modify-write pipeline with hazard forwarding,
// optional saturation, a registered read port and a clear sweep after reset.
module client_accum_ram #(
  parameter int unsigned D_WIDTH  = 32,
  parameter int unsigned A_WIDTH  = 5,
  parameter int unsigned A_MAX    = 32,
  parameter int unsigned SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [1:0]         wr_mode,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               memwr,
  output logic               sat_flag,
  output logic               busy
);

  typedef enum logic [0:0] {StInit, StRun} state_t;

  localparam logic [1:0] ModeWrite = 2'b00;
  localparam logic [1:0] ModeAdd   = 2'b01;
  localparam logic [1:0] ModeSub   = 2'b10;
  localparam logic [1:0] ModeClear = 2'b11;

  state_t               state_q;
  logic [A_WIDTH-1:0]   sweep_cnt_q;
  logic                 wr_ready_q;
  logic                 busy_q;

  logic [D_WIDTH-1:0]   mem [A_MAX];

  // Commit stage: holds the request accepted in the previous cycle.
  logic                 s2_valid_q;
  logic [A_WIDTH-1:0]   s2_addr_q;
  logic [1:0]           s2_mode_q;
  logic [D_WIDTH-1:0]   s2_data_q;
  logic [D_WIDTH-1:0]   s2_old_q;

  logic [D_WIDTH:0]     sum;
  logic [D_WIDTH:0]     diff;
  logic [D_WIDTH-1:0]   result;
  logic                 sat;
  logic                 accept;
  logic [D_WIDTH-1:0]   old_d;

  logic [D_WIDTH-1:0]   rd_data_q;
  logic                 rd_valid_q;

  assign accept   = wr_valid & wr_ready_q;
  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign memwr    = s2_valid_q;
  assign sat_flag = s2_valid_q & sat;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      sweep_cnt_q <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (sweep_cnt_q == A_WIDTH'(A_MAX - 1)) begin
            state_q    <= StRun;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        StRun: begin
          wr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // MSB of the widened sum/difference is the carry/borrow.
  always_comb begin
    sum    = {1'b0, s2_old_q} + {1'b0, s2_data_q};
    diff   = {1'b0, s2_old_q} - {1'b0, s2_data_q};
    result = '0;
    sat    = 1'b0;
    unique case (s2_mode_q)
      ModeWrite: result = s2_data_q;
      ModeAdd: begin
        if ((SATURATE != 0) && sum[D_WIDTH]) begin
          result = '1;
          sat    = 1'b1;
        end else begin
          result = sum[D_WIDTH-1:0];
        end
      end
      ModeSub: begin
        if ((SATURATE != 0) && diff[D_WIDTH]) begin
          result = '0;
          sat    = 1'b1;
        end else begin
          result = diff[D_WIDTH-1:0];
        end
      end
      ModeClear: result = '0;
      default:   result = '0;
    endcase
  end

  // Forward the committing result so back-to-back updates to one client are not lost.
  assign old_d = (s2_valid_q && (s2_addr_q == wr_addr)) ? result : mem[wr_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_mode_q  <= ModeWrite;
      s2_data_q  <= '0;
      s2_old_q   <= '0;
    end else begin
      s2_valid_q <= accept;
      if (accept) begin
        s2_addr_q <= wr_addr;
        s2_mode_q <= wr_mode;
        s2_data_q <= wr_data;
        s2_old_q  <= old_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[sweep_cnt_q] <= '0;
    end else if (s2_valid_q) begin
      mem[s2_addr_q] <= result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en && (state_q == StRun);
      if (rd_en && (state_q == StRun)) begin
        rd_data_q <= (s2_valid_q && (s2_addr_q == rd_addr)) ? result : mem[rd_addr];
      end
    end
  end

endmodule

// File: doc/client_accum_ram.md
Name: client_accum_ram

Overview:
- Per-client accumulator memory, indexed by client ID.
- Each write request carries a mode: overwrite, accumulate-add, accumulate-subtract or clear. The block performs a pipelined read-modify-write with hazard forwarding and optional saturation.
- Has one read port and one write/accumulate port, plus a self-initialising clear sweep after reset.
- Sits downstream of order-cancel parsing and holds the running cancelled-order value per client.

Parameters:
- D_WIDTH, 32, accumulator data width (unsigned).
- A_WIDTH, 5, client-ID address width.
- A_MAX, 32, number of entries; must equal 2^A_WIDTH.
- SATURATE, 1, 1 = clamp add/subtract results at the range limits; 0 = wrap modulo 2^D_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write/accumulate request valid.
- wr_ready  out  1  block can accept a request this cycle.
- wr_addr  in  A_WIDTH  client ID to update.
- wr_data  in  D_WIDTH  operand.
- wr_mode  in  2  00 write, 01 add, 10 subtract, 11 clear (wr_data ignored).
- rd_en  in  1  read request.
- rd_addr  in  A_WIDTH  client ID to read.
- rd_data  out  D_WIDTH  read result, registered.
- rd_valid  out  1  rd_data valid this cycle.
- memwr  out  1  one-cycle pulse when an update commits to memory.
- sat_flag  out  1  one-cycle pulse, coincident with memwr, when the committed result was clamped.
- busy  out  1  init sweep in progress.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ready=0, rd_data=0, rd_valid=0, memwr=0, sat_flag=0, busy=1.
  - Pipeline registers are cleared; sweep counter=0; state=INIT.
- INIT state:
  - Entered on reset deassert.
  - Writes 0 to address sweep_cnt each cycle, 0 to A_MAX-1 (A_MAX cycles).
  - busy=1, wr_ready=0. rd_en is ignored (rd_valid stays 0).
  - After the write to A_MAX-1, state goes to RUN next cycle: busy=0, wr_ready=1.
- RUN state:
  - wr_ready=1 permanently; throughput is 1 request/cycle.
- Update pipeline:
  - Cycle T: a request is accepted on wr_valid & wr_ready. Stage S1 latches addr/mode/data and reads old = memory[addr].
  - Cycle T+1: stage S2 computes the result, writes memory, and memwr=1 (sat_flag as applicable).
  - Result by mode:
    - write: data.
    - add: old+data.
    - subtract: old-data.
    - clear: 0.
- Forwarding:
  - If the S1 address equals the S2 address of the request committing that cycle, old is taken from the S2 result, not memory.
  - Back-to-back adds to the same client must therefore never lose an update.
- Saturation (SATURATE=1):
  - An add carry-out forces the result to all ones.
  - A subtract borrow forces the result to 0.
  - sat_flag pulses in either case.
  - With SATURATE=0 the result wraps and sat_flag stays 0.
  - Write and clear never set sat_flag.
- Read port:
  - rd_en at cycle T gives rd_data = memory[rd_addr] and rd_valid=1 at T+1.
  - rd_valid=0 when rd_en was 0; rd_data holds its last value.
  - Write-first bypass: if an S2 commit to rd_addr occurs in cycle T, rd_data at T+1 is the new committed value.
  - A request still in S1 at T is not visible to that read.
- Simultaneous read and update to different addresses are independent; no stall.
- wr_valid while wr_ready=0 is dropped, not queued. The upstream must hold the request until wr_ready=1.
- Reset mid-operation:
  - The in-flight S1/S2 request is discarded with no memwr.
  - All entries are re-zeroed by a new INIT sweep.
- Width rule: all arithmetic is unsigned D_WIDTH+1 internally; the MSB is used only for carry/borrow detection.

Test Plan:
- Reset release, D_WIDTH=32, A_MAX=32:
  - busy=1 and wr_ready=0 for exactly 32 cycles after rst_n rises, then busy=0 and wr_ready=1.
  - Reads of all 32 addresses return 0.
- Write then add:
  - write addr 3 value 100, then add addr 3 value 25; memwr pulses each cycle after acceptance.
  - Read addr 3 gives rd_data=125 one cycle after rd_en.
- Back-to-back forwarding:
  - Four consecutive adds of 10 to addr 7 in four cycles.
  - Read after the last memwr returns 40, with no lost update.
- Saturation:
  - SATURATE=1: write addr 1 0xFFFFFFF0, add 0x20 gives 0xFFFFFFFF with sat_flag=1; subtract 5 from 0 gives 0 with sat_flag=1.
  - SATURATE=0: the same add gives 0x00000010 and sat_flag=0.
- Read/commit collision:
  - Add commits to addr 5 (old 8, +2) in the same cycle rd_en targets addr 5.
  - rd_data=10 next cycle.
- Mid-operation reset:
  - Assert rst_n=0 with adds to addr 2 in S1 and S2: memwr stays 0.
  - After re-init, addr 2 reads 0 and busy runs 32 cycles.
